// File: rtl/seg_pkg.sv
// Shared types and constants for the BCD counter / seven-segment display block.
package seg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low a..g in bits 0..6, dp (bit 7) held off; entry 0 is leftmost.
  localparam logic [0:9][7:0] SEG_LUT = {
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// One-digit BCD to active-low seven-segment decoder with a blank override.
module bcd_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank && i_digit <= 4'd9) o_seg = SEG_LUT[i_digit];
  end

endmodule

// File: rtl/seg_counter_display.sv
// Multi-digit BCD up/down/load counter driving registered active-low HEX segments.
module seg_counter_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 10,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    enable,
  input  logic [3:0]              bcd_in,
  input  logic                    load,
  output logic [8*NUM_DIGITS-1:0] seg_out,
  output logic                    wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  mode_e                       w_mode;
  mode_e                       r_mode_q;
  logic [1:0]                  r_sync;
  logic                        r_load_q;
  logic                        r_edge;
  logic [PW-1:0]               r_pre;
  logic                        w_run;
  logic                        w_dir_sw;
  logic                        w_tick;
  bcd_t [NUM_DIGITS-1:0]       r_dig;
  bcd_t [NUM_DIGITS-1:0]       w_nxt;
  logic                        w_carry;
  logic                        w_wrap_nxt;
  logic                        r_wrap;
  logic                        w_zero_above;
  logic [NUM_DIGITS-1:0]       w_blank;
  logic [NUM_DIGITS-1:0][7:0]  w_seg;
  logic [NUM_DIGITS-1:0][7:0]  r_seg;

  assign w_mode = mode_e'(mode);

  // Key level is asynchronous: two-flop synchronizer, then a registered rising-edge pulse.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync   <= '0;
      r_load_q <= 1'b0;
      r_edge   <= 1'b0;
      r_mode_q <= MODE_HOLD;
    end else begin
      r_sync   <= {r_sync[0], load};
      r_load_q <= r_sync[1];
      r_edge   <= r_sync[1] & ~r_load_q;
      r_mode_q <= w_mode;
    end
  end

  // A direct up<->down switch restarts the period so no partial tick leaks across.
  assign w_run    = enable && (w_mode == MODE_UP || w_mode == MODE_DOWN);
  assign w_dir_sw = (w_mode != r_mode_q) && (r_mode_q == MODE_UP || r_mode_q == MODE_DOWN);
  assign w_tick   = w_run && !w_dir_sw && (r_pre == PW'(DIV - 1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                           r_pre <= '0;
    else if (!w_run || w_dir_sw || w_tick) r_pre <= '0;
    else                                 r_pre <= r_pre + 1'b1;
  end

  always_comb begin
    w_nxt      = r_dig;
    w_carry    = 1'b1;
    w_wrap_nxt = 1'b0;
    if (r_edge && w_mode == MODE_LOAD && bcd_in <= 4'd9) begin
      for (int k = NUM_DIGITS - 1; k > 0; k--) w_nxt[k] = r_dig[k-1];
      w_nxt[0] = bcd_in;
    end else if (w_tick && w_mode == MODE_UP) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (w_carry) begin
          if (r_dig[k] == 4'd9) w_nxt[k] = 4'd0;
          else begin
            w_nxt[k] = r_dig[k] + 4'd1;
            w_carry  = 1'b0;
          end
        end
      end
      w_wrap_nxt = w_carry;
    end else if (w_tick && w_mode == MODE_DOWN) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (w_carry) begin
          if (r_dig[k] == 4'd0) w_nxt[k] = 4'd9;
          else begin
            w_nxt[k] = r_dig[k] - 4'd1;
            w_carry  = 1'b0;
          end
        end
      end
      w_wrap_nxt = w_carry;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_dig  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_dig  <= w_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  // Blank every digit whose own position and all positions above it are zero.
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_zero_above = w_zero_above && (r_dig[k] == 4'd0);
      w_blank[k]   = (BLANK_LZ != 0) && w_zero_above;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_to_7seg u_dec (
      .i_digit (r_dig[g]),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg[g])
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) r_seg[g] <= (g == 0 || BLANK_LZ == 0) ? SEG_LUT[0] : SEG_BLANK;
      else       r_seg[g] <= w_seg[g];
    end
  end

  assign seg_out = r_seg;
  assign wrap    = r_wrap;

endmodule
